copro_axil_regs: RTL

AXI4-Lite slave register bank for the copro coprocessor peripheral. It sits directly downstream of the AXI master (the VIP in simulation, the PS interconnect in hardware). It decodes single-beat reads and writes into four 32-bit read/write registers, and presents them to the coprocessor core as a parallel bus with per-register write strobes.

---
 rtl/copro_regs_pkg.sv | 24 ++
 rtl/copro_reg_file.sv | 41 ++++
 rtl/copro_axil_regs.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/copro_regs_pkg.sv
// Shared constants and types for the copro AXI4-Lite register bank.
package copro_regs_pkg;

    localparam int unsigned NUM_REGS  = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned REG_IDX_W = $clog2(NUM_REGS);

    localparam int unsigned REG_CTRL = 0;
    localparam int unsigned REG_OPA  = 1;
    localparam int unsigned REG_OPB  = 2;
    localparam int unsigned REG_RES  = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WS_IDLE = 2'd0,
        WS_ADDR = 2'd1,
        WS_DATA = 2'd2,
        WS_RESP = 2'd3
    } wr_state_e;

endpackage

// File: rtl/copro_reg_file.sv
// Byte-enabled 4x32 register storage: synchronous write port, combinational read port.
module copro_reg_file
    import copro_regs_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [REG_IDX_W-1:0]             wr_idx,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic [STRB_W-1:0]                wr_strb,
    input  logic [REG_IDX_W-1:0]             rd_idx,
    output logic [DATA_W-1:0]                rd_data_c,
    output logic [NUM_REGS-1:0][DATA_W-1:0]  regs
);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data_c = mem_q[rd_idx];
    assign regs      = mem_q;

endmodule

// File: rtl/copro_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit registers to the copro core.
// Define COPRO_REGS_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.
module copro_axil_regs
    import copro_regs_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                                         ACLK,
    input  logic                                         ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_AWADDR,
    input  logic [2:0]                                   S_AXI_AWPROT,
    input  logic                                         S_AXI_AWVALID,
    output logic                                         S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
    input  logic                                         S_AXI_WVALID,
    output logic                                         S_AXI_WREADY,
    output logic [1:0]                                   S_AXI_BRESP,
    output logic                                         S_AXI_BVALID,
    input  logic                                         S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_ARADDR,
    input  logic [2:0]                                   S_AXI_ARPROT,
    input  logic                                         S_AXI_ARVALID,
    output logic                                         S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_RDATA,
    output logic [1:0]                                   S_AXI_RRESP,
    output logic                                         S_AXI_RVALID,
    input  logic                                         S_AXI_RREADY,
    output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0]  reg_q,
    output logic [NUM_REGS-1:0]                          reg_wr
);

    localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - 2;
`ifdef COPRO_REGS_SLVERR_EN
    localparam logic [1:0] UNMAPPED_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] UNMAPPED_RESP = RESP_OKAY;
`endif

    wr_state_e                 state_q, state_d;
    logic [IDX_W-1:0]          awidx_q, awidx_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d;
    logic [STRB_W-1:0]         wstrb_q, wstrb_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [NUM_REGS-1:0]       reg_wr_q, reg_wr_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic [DATA_W-1:0]         rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;

    logic                      aw_hs_c, w_hs_c, ar_hs_c;
    logic                      commit_c, wr_mapped_c, rd_mapped_c;
    logic [IDX_W-1:0]          ar_idx_c;
    logic [DATA_W-1:0]         rf_rdata_c;
    logic                      unused_c;

    assign aw_hs_c     = S_AXI_AWVALID && awready_q;
    assign w_hs_c      = S_AXI_WVALID && wready_q;
    assign ar_hs_c     = S_AXI_ARVALID && arready_q;
    assign ar_idx_c    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_mapped_c = ar_idx_c < IDX_W'(NUM_REGS);
    assign unused_c    = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write FSM; the commit uses whichever of AW/W arrives on this edge or was latched earlier.
    always_comb begin
        state_d     = state_q;
        awidx_d     = awidx_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        reg_wr_d    = '0;
        commit_c    = 1'b0;

        if (aw_hs_c) begin
            awidx_d = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end
        if (w_hs_c) begin
            wdata_d = S_AXI_WDATA;
            wstrb_d = S_AXI_WSTRB;
        end
        wr_mapped_c = awidx_d < IDX_W'(NUM_REGS);

        case (state_q)
            WS_IDLE: begin
                if (aw_hs_c && w_hs_c) begin
                    commit_c = 1'b1;
                end else if (aw_hs_c) begin
                    state_d = WS_ADDR;
                end else if (w_hs_c) begin
                    state_d = WS_DATA;
                end
            end
            WS_ADDR: commit_c = w_hs_c;
            WS_DATA: commit_c = aw_hs_c;
            WS_RESP: begin
                if (S_AXI_BREADY) begin
                    state_d  = WS_IDLE;
                    bvalid_d = 1'b0;
                end
            end
            default: state_d = WS_IDLE;
        endcase

        if (commit_c) begin
            state_d  = WS_RESP;
            bvalid_d = 1'b1;
            bresp_d  = wr_mapped_c ? RESP_OKAY : UNMAPPED_RESP;
            if (wr_mapped_c && (|wstrb_d)) begin
                reg_wr_d[awidx_d[REG_IDX_W-1:0]] = 1'b1;
            end
        end

        awready_d = (state_d == WS_IDLE) || (state_d == WS_DATA);
        wready_d  = (state_d == WS_IDLE) || (state_d == WS_ADDR);
    end

    // Read path: one outstanding read, data captured on the AR handshake.
    always_comb begin
        rvalid_d = rvalid_q && !S_AXI_RREADY;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs_c) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mapped_c ? rf_rdata_c : '0;
            rresp_d  = rd_mapped_c ? RESP_OKAY : UNMAPPED_RESP;
        end
        arready_d = !rvalid_d;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= WS_IDLE;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            reg_wr_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            reg_wr_q  <= reg_wr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    copro_reg_file u_reg_file (
        .clk       (ACLK),
        .rst       (ARESET),
        .wr_en     (commit_c && wr_mapped_c),
        .wr_idx    (awidx_d[REG_IDX_W-1:0]),
        .wr_data   (wdata_d),
        .wr_strb   (wstrb_d),
        .rd_idx    (ar_idx_c[REG_IDX_W-1:0]),
        .rd_data_c (rf_rdata_c),
        .regs      (reg_q)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign reg_wr        = reg_wr_q;

endmodule
